// File: rtl/paddle_ctrl.sv
// paddle_ctrl: N independent paddle channels. Each channel synchronises and
// debounces its up/down buttons and runs an accelerating IDLE/UP/DOWN FSM,
// or tracks the ball in auto mode. All state advances on the animate pulse.

module paddle_ch #(
  parameter int COORD_W     = 12,
  parameter int SCREEN_H    = 480,
  parameter int BAR_LEN     = 180,
  parameter int STEP        = 4,
  parameter int ACCEL       = 1,
  parameter int MAX_STEP    = 12,
  parameter int HOLD_FRAMES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               animate,
  input  logic               freeze,
  input  logic               auto_mode,
  input  logic               up_raw,
  input  logic               dn_raw,
  input  logic [COORD_W-1:0] ball_y,
  output logic [COORD_W-1:0] y1,
  output logic [COORD_W-1:0] y2,
  output logic               moving
);
  localparam int SW = COORD_W + 1;
  typedef logic signed [SW-1:0] sc_t;
  localparam sc_t        Y_MAX  = sc_t'(SCREEN_H - BAR_LEN);
  localparam sc_t        Y_RST  = sc_t'((SCREEN_H - BAR_LEN) / 2);
  localparam sc_t        S_STEP = sc_t'(STEP);
  localparam sc_t        S_ACC  = sc_t'(ACCEL);
  localparam sc_t        S_MAX  = sc_t'(MAX_STEP);
  localparam sc_t        HALF   = sc_t'(BAR_LEN / 2);
  localparam logic [3:0] HOLD   = 4'(HOLD_FRAMES);

  typedef enum logic [1:0] {S_IDLE, S_UP, S_DN} st_t;

  st_t               state_q;
  logic [1:0]        up_sync_q, dn_sync_q;
  logic [3:0]        cnt_up_q, cnt_dn_q, cnt_up_d, cnt_dn_d;
  sc_t               y1_q, spd_q;
  logic [COORD_W-1:0] y2_q;
  logic              moving_q;
  sc_t               spd_up_d, spd_dn_d, y_up_d, y_dn_d, y_auto_d, y_d;
  sc_t               tgt, diff, adist;
  logic              up_v, dn_v;

  // Two-flop synchronisers on the raw buttons, free running
  always_ff @(posedge clk) begin
    if (rst) begin
      up_sync_q <= '0;
      dn_sync_q <= '0;
    end else begin
      up_sync_q <= {up_sync_q[0], up_raw};
      dn_sync_q <= {dn_sync_q[0], dn_raw};
    end
  end

  // Next debounce counts, speeds and candidate positions for this frame
  always_comb begin
    cnt_up_d = '0;
    if (up_sync_q[1]) cnt_up_d = (cnt_up_q >= HOLD) ? HOLD : cnt_up_q + 4'd1;
    cnt_dn_d = '0;
    if (dn_sync_q[1]) cnt_dn_d = (cnt_dn_q >= HOLD) ? HOLD : cnt_dn_q + 4'd1;
    up_v = (cnt_up_d == HOLD);
    dn_v = (cnt_dn_d == HOLD);

    // speed restarts on entry (incl. reversal), accelerates while staying
    spd_up_d = S_STEP;
    if (state_q == S_UP) spd_up_d = (spd_q + S_ACC > S_MAX) ? S_MAX : spd_q + S_ACC;
    spd_dn_d = S_STEP;
    if (state_q == S_DN) spd_dn_d = (spd_q + S_ACC > S_MAX) ? S_MAX : spd_q + S_ACC;

    y_up_d = y1_q - spd_up_d;
    if (y_up_d < sc_t'(0)) y_up_d = sc_t'(0);
    y_dn_d = y1_q + spd_dn_d;
    if (y_dn_d > Y_MAX) y_dn_d = Y_MAX;

    // auto tracking: clamp target into range, step at most STEP toward it
    tgt = sc_t'({1'b0, ball_y}) - HALF;
    if (tgt < sc_t'(0)) tgt = sc_t'(0);
    if (tgt > Y_MAX)    tgt = Y_MAX;
    diff  = tgt - y1_q;
    adist = (diff < sc_t'(0)) ? -diff : diff;
    if (adist > S_STEP) adist = S_STEP;
    y_auto_d = (diff < sc_t'(0)) ? y1_q - adist : y1_q + adist;

    y_d = y1_q;
    if (freeze)              y_d = y1_q;
    else if (auto_mode)      y_d = y_auto_d;
    else if (up_v && !dn_v)  y_d = y_up_d;
    else if (dn_v && !up_v)  y_d = y_dn_d;
  end

  // Per-frame FSM, speed, position and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      spd_q    <= S_STEP;
      y1_q     <= Y_RST;
      y2_q     <= COORD_W'((SCREEN_H - BAR_LEN) / 2 + BAR_LEN);
      moving_q <= 1'b0;
      cnt_up_q <= '0;
      cnt_dn_q <= '0;
    end else if (animate) begin
      y1_q     <= y_d;
      y2_q     <= y_d[COORD_W-1:0] + COORD_W'(BAR_LEN);
      moving_q <= (y_d != y1_q);
      if (freeze || auto_mode) begin
        state_q  <= S_IDLE;
        cnt_up_q <= '0;
        cnt_dn_q <= '0;
        if (!freeze) spd_q <= S_STEP;  // freeze holds speed
      end else begin
        cnt_up_q <= cnt_up_d;
        cnt_dn_q <= cnt_dn_d;
        if (up_v && !dn_v) begin
          state_q <= S_UP;
          spd_q   <= spd_up_d;
        end else if (dn_v && !up_v) begin
          state_q <= S_DN;
          spd_q   <= spd_dn_d;
        end else begin
          state_q <= S_IDLE;
          spd_q   <= S_STEP;
        end
      end
    end
  end

  assign y1     = y1_q[COORD_W-1:0];
  assign y2     = y2_q;
  assign moving = moving_q;
endmodule

module paddle_ctrl #(
  parameter int N_PAD       = 2,
  parameter int COORD_W     = 12,
  parameter int SCREEN_H    = 480,
  parameter int BAR_LEN     = 180,
  parameter int STEP        = 4,
  parameter int ACCEL       = 1,
  parameter int MAX_STEP    = 12,
  parameter int HOLD_FRAMES = 2
) (
  input  logic                       in_clock,
  input  logic                       in_reset,
  input  logic                       in_animate,
  input  logic [N_PAD-1:0]           in_up,
  input  logic [N_PAD-1:0]           in_down,
  input  logic [N_PAD-1:0]           in_auto,
  input  logic [COORD_W-1:0]         in_ball_y,
  input  logic                       in_freeze,
  output logic [N_PAD*COORD_W-1:0]   out_y1,
  output logic [N_PAD*COORD_W-1:0]   out_y2,
  output logic [N_PAD-1:0]           out_moving
);
  for (genvar g = 0; g < N_PAD; g++) begin : g_ch
    paddle_ch #(
      .COORD_W(COORD_W), .SCREEN_H(SCREEN_H), .BAR_LEN(BAR_LEN), .STEP(STEP),
      .ACCEL(ACCEL), .MAX_STEP(MAX_STEP), .HOLD_FRAMES(HOLD_FRAMES)
    ) u_ch (
      .clk      (in_clock),
      .rst      (in_reset),
      .animate  (in_animate),
      .freeze   (in_freeze),
      .auto_mode(in_auto[g]),
      .up_raw   (in_up[g]),
      .dn_raw   (in_down[g]),
      .ball_y   (in_ball_y),
      .y1       (out_y1[g*COORD_W +: COORD_W]),
      .y2       (out_y2[g*COORD_W +: COORD_W]),
      .moving   (out_moving[g])
    );
  end
endmodule
